// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two requesters, one response consumer and alu_arbiter.
// The flag signals exist only when ALU_ARB_FLAGS_EN is defined.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_b0;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [2:0]  req_op0;
  logic [2:0]  req_op1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;
`ifdef ALU_ARB_FLAGS_EN
  logic        rsp_zero;
  logic        rsp_ovf;
  logic        rsp_cout;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, rsp_zero, rsp_ovf, rsp_cout
  );
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, rsp_zero, rsp_ovf, rsp_cout
  );
`else
  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin front-end sharing one 32-bit ALU between two requesters (IDLE/EXEC/DONE).
// Optional flag outputs (zero/ovf/cout) are built when ALU_ARB_FLAGS_EN is defined.
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf,
  output logic        cout,
  output logic        illegal
);
  logic        sub;
  logic [31:0] b_eff;
  logic [32:0] sum33;
  logic        add_ovf;

  // One adder serves add, sub and slt; subtraction is a + ~b + 1.
  always_comb begin
    sub     = (op == 3'b110) || (op == 3'b111);
    b_eff   = sub ? ~b : b;
    sum33   = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub};
    add_ovf = (a[31] == b_eff[31]) && (sum33[31] != a[31]);
    result  = 32'd0;
    ovf     = 1'b0;
    cout    = 1'b0;
    illegal = 1'b0;
    case (op)
      3'b000: result = a & b;
      3'b001: result = a | b;
      3'b010, 3'b110: begin
        result = sum33[31:0];
        ovf    = add_ovf;
        cout   = sum33[32];
      end
      3'b111: result = {31'd0, sum33[31] ^ add_ovf};
      default: illegal = 1'b1;
    endcase
    zero = (result == 32'd0) && !illegal;
  end
endmodule

module alu_arbiter (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_err_q, rsp_err_d;
  logic        grant;
  logic [1:0]  req_ready;
  logic [31:0] alu_result;
  logic        alu_zero, alu_ovf, alu_cout, alu_illegal;
`ifdef ALU_ARB_FLAGS_EN
  logic        zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d;
`else
  logic [2:0]  unused_flags;
  assign unused_flags = {alu_zero, alu_ovf, alu_cout};
`endif

  alu u_alu (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .result  (alu_result),
    .zero    (alu_zero),
    .ovf     (alu_ovf),
    .cout    (alu_cout),
    .illegal (alu_illegal)
  );

  // Next-state, grant selection and operand/result capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = 2'b00;
`ifdef ALU_ARB_FLAGS_EN
    zero_d = zero_q;
    ovf_d  = ovf_q;
    cout_d = cout_q;
`endif
    if (bus.req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req_valid[1];
    end
    case (state_q)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          req_ready    = grant ? 2'b10 : 2'b01;
          a_d          = grant ? bus.req_a1 : bus.req_a0;
          b_d          = grant ? bus.req_b1 : bus.req_b0;
          op_d         = grant ? bus.req_op1 : bus.req_op0;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_err_d    = alu_illegal;
        rsp_valid_d  = 1'b1;
`ifdef ALU_ARB_FLAGS_EN
        zero_d = alu_zero;
        ovf_d  = alu_ovf;
        cout_d = alu_cout;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= 3'd0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      cout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_ARB_FLAGS_EN
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      cout_q <= cout_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
`ifdef ALU_ARB_FLAGS_EN
  assign bus.rsp_zero = zero_q;
  assign bus.rsp_ovf  = ovf_q;
  assign bus.rsp_cout = cout_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single transactions plus
// hand-written sequences for arbitration, back-pressure and mid-transaction reset.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    logic        zero;
    logic        ovf;
    logic        cout;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    if (v.id) begin
      bus.req_a1 = v.a; bus.req_b1 = v.b; bus.req_op1 = v.op; bus.req_valid = 2'b10;
    end else begin
      bus.req_a0 = v.a; bus.req_b0 = v.b; bus.req_op0 = v.op; bus.req_valid = 2'b01;
    end
    #1;
    check($sformatf("v%0d_req_ready", idx), 32'(bus.req_ready), v.id ? 32'd2 : 32'd1);
    step();
    bus.req_valid = 2'b00;
    check($sformatf("v%0d_exec_rsp_valid", idx), 32'(bus.rsp_valid), 32'd0);
    step();
    check($sformatf("v%0d_rsp_valid", idx), 32'(bus.rsp_valid), 32'd1);
    check($sformatf("v%0d_result", idx), bus.rsp_result, v.res);
    check($sformatf("v%0d_err", idx), 32'(bus.rsp_err), 32'(v.err));
    check($sformatf("v%0d_id", idx), 32'(bus.rsp_id), 32'(v.id));
`ifdef ALU_ARB_FLAGS_EN
    check($sformatf("v%0d_zero", idx), 32'(bus.rsp_zero), 32'(v.zero));
    check($sformatf("v%0d_ovf", idx), 32'(bus.rsp_ovf), 32'(v.ovf));
    check($sformatf("v%0d_cout", idx), 32'(bus.rsp_cout), 32'(v.cout));
`endif
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_drop", idx), 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int got;
    int last_cyc;

    //         id    op      a              b              result         err   zero  ovf   cout
    vecs[0]  = '{1'b0, 3'b010, 32'd5,         32'd3,         32'd8,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3'b111, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3'b001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'b100, 32'd3,         32'd4,         32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3'b011, 32'd3,         32'd4,         32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'b101, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3'b110, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b110, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'b110, 32'd7,         32'd7,         32'd0,         1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    bus.req_a0 = 32'd0; bus.req_b0 = 32'd0; bus.req_op0 = 3'd0;
    bus.req_a1 = 32'd0; bus.req_b1 = 32'd0; bus.req_op1 = 3'd0;
    step();
    step();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
`ifdef ALU_ARB_FLAGS_EN
    check("rst_flags", {29'd0, bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_vec(i, vecs[i]);
    end

    // Both requesters valid every cycle: grants alternate, one response per 3 cycles.
    reset_pulse();
    bus.req_a0 = 32'd7; bus.req_b0 = 32'd7; bus.req_op0 = 3'b110;
    bus.req_a1 = 32'd7; bus.req_b1 = 32'd7; bus.req_op1 = 3'b110;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    got = 0;
    last_cyc = -1;
    for (int c = 0; c < 30 && got < 6; c++) begin
      step();
      if (bus.rsp_valid) begin
        check($sformatf("rr%0d_id", got), 32'(bus.rsp_id), 32'(got % 2));
        check($sformatf("rr%0d_result", got), bus.rsp_result, 32'd0);
`ifdef ALU_ARB_FLAGS_EN
        check($sformatf("rr%0d_zero", got), 32'(bus.rsp_zero), 32'd1);
`endif
        if (got > 0) begin
          check($sformatf("rr%0d_interval", got), 32'(c - last_cyc), 32'd3);
        end else begin
          check("rr0_first_cycle", 32'(c), 32'd1);
        end
        last_cyc = c;
        got++;
      end
    end
    check("rr_count", 32'(got), 32'd6);
    bus.req_valid = 2'b00;
    step();
    bus.rsp_ready = 1'b0;

    // Back-pressure: response held 5 cycles, requester 1 locked out until after the handshake.
    reset_pulse();
    bus.req_a0 = 32'h7FFF_FFFF; bus.req_b0 = 32'd1; bus.req_op0 = 3'b010;
    bus.req_a1 = 32'd1; bus.req_b1 = 32'd2; bus.req_op1 = 3'b010;
    bus.req_valid = 2'b11;
    #1;
    check("bp_tie_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b10;
    #1;
    check("bp_exec_ready", 32'(bus.req_ready), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp%0d_result", k), bus.rsp_result, 32'h8000_0000);
      check($sformatf("bp%0d_id", k), 32'(bus.rsp_id), 32'd0);
      check($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 32'd0);
`ifdef ALU_ARB_FLAGS_EN
      check($sformatf("bp%0d_ovf", k), 32'(bus.rsp_ovf), 32'd1);
`endif
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_hs_ready", 32'(bus.req_ready), 32'd0);
    check("bp_hs_valid", 32'(bus.rsp_valid), 32'd1);
    step();
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_after_ready", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 2'b00;
    step();
    check("bp_r1_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_r1_id", 32'(bus.rsp_id), 32'd1);
    check("bp_r1_result", bus.rsp_result, 32'd3);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Reset in EXEC discards the transaction and restores requester 0 tie priority.
    bus.req_a0 = 32'd10; bus.req_b0 = 32'd20; bus.req_op0 = 3'b010;
    bus.req_valid = 2'b01;
    #1;
    check("rx_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rx%0d_no_rsp", k), 32'(bus.rsp_valid), 32'd0);
      step();
    end
    bus.req_valid = 2'b11;
    #1;
    check("rx_tie_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b00;
    step();
    check("rx_valid", 32'(bus.rsp_valid), 32'd1);
    check("rx_id", 32'(bus.rsp_id), 32'd0);
    check("rx_result", bus.rsp_result, 32'd30);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequential front-end that shares one 32-bit `alu` instance between two requesters. Each requester uses a valid/ready handshake. Arbitration is round-robin. Operands are registered, the ALU result is captured one cycle later, and the response is held until the consumer accepts it. It sits between the decode/issue logic of two pipelines (or a pipeline and a debug/test port) and the single ALU datapath.

## Interface
- `NREQ`, 2, number of requesters; fixed at 2, round-robin pointer is 1 bit
- `clk` input 1 rising-edge clock
- `reset` input 1 synchronous, active-high reset
- `req_valid` input [1:0] per-requester request valid
- `req_ready` output [1:0] per-requester accept; at most one bit high
- `req_a0`, `req_b0` input [31:0] requester 0 operands
- `req_a1`, `req_b1` input [31:0] requester 1 operands
- `req_op0`, `req_op1` input [2:0] ALU op (000 and, 001 or, 010 add, 110 sub, 111 slt)
- `rsp_valid` output 1 response valid
- `rsp_ready` input 1 consumer accepts response
- `rsp_id` output 1 requester index that owns the response
- `rsp_result` output [31:0] result
- `rsp_err` output 1 illegal op (011, 100, 101)
- `rsp_zero`, `rsp_ovf`, `rsp_cout` output 1 ALU flags (present only with `ALU_ARB_FLAGS_EN`)

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - grant = requester with `req_valid`; if both valid, grant = requester != `last_grant`.
  - `req_ready[grant]`=1 combinationally, only in IDLE.
  - Handshake (valid&ready) latches a, b, op, id; sets `last_grant`=id; go to EXEC.
- EXEC: the internal `alu` sees the latched operands. The result is captured as follows:
  - op 111: `{31'b0, set}`.
  - op 000/001/010/110: ALU `result`.
  - illegal op: result 0, `rsp_err`=1, flags 0.
  - Go to DONE.
- DONE:
  - `rsp_valid`=1; all `rsp_*` stable.
  - When `rsp_ready`=1, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Requester inputs are ignored outside IDLE. A requester dropping `req_valid` while not granted is legal.
- Reset values: state IDLE, `last_grant`=1 (requester 0 wins the first tie), `req_ready`=00, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_err`=0, all flags 0.
- Reset asserted mid-transaction (EXEC or DONE) discards the transaction. The response is never presented.
- Width rules: all arithmetic is 32-bit two's complement inside the ALU. `rsp_cout` is the ALU carry out. `rsp_ovf` is the ALU overflow flag as computed by the ALU.

## Timing
- Request accepted at edge N (IDLE), EXEC in cycle N+1, `rsp_valid`=1 from cycle N+2.
- Minimum issue interval: 3 cycles per request (IDLE, EXEC, DONE).
- The response is held indefinitely under `rsp_ready`=0.
- Both requesters continuously valid: grants alternate 0,1,0,1…
- Zero combinational path from `rsp_ready` to `req_ready`. `req_ready` depends only on state, `req_valid`, and `last_grant`.

## Configuration
- `ALU_ARB_FLAGS_EN` defined:
  - `rsp_zero`, `rsp_ovf`, and `rsp_cout` ports exist.
  - They are captured in EXEC alongside the result and held in DONE.
- Not defined: the ports and their registers are absent. `rsp_result`, `rsp_err`, and `rsp_id` are unchanged.

## Test plan
- Reset, then requester 0 only, a=5, b=3, op=010 -> `req_ready`=01 same cycle; `rsp_valid` 2 cycles later with result=8, id=0, err=0, zero=0.
- Both valid every cycle, op=110, a=7, b=7 on both, `rsp_ready`=1 -> ids alternate 0,1,0,1; result=0, zero=1; one response per 3 cycles.
- Requester 1, op=111, a=-1, b=1 -> result=1. Then a=1, b=-1 -> result=0.
- Requester 0, add a=0x7FFFFFFF, b=1, `rsp_ready` held 0 for 5 cycles -> result=0x80000000, ovf=1 stable for all 5 cycles. Requester 1 valid throughout sees `req_ready`=0 until the cycle after the response handshake.
- Op=100 -> err=1, result=0. Reset asserted in EXEC -> `rsp_valid` never rises; next request completes normally with `last_grant` reset (requester 0 wins tie).
